// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, funct7 values, ALU codes, immediate
// formats and the DE/EX pipeline slot layout.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // One DE/EX slot; all-zero is a bubble.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  funct3;
        alu_op_e     alu_op;
        logic        src_a_pc;
        logic        src_b_imm;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic        branch;
        logic        jump;
        logic        illegal;
    } de_t;

    // ALU op selected by funct3 for the base (funct7 = 0) OP/OP-IMM encodings.
    function automatic alu_op_e base_alu_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Immediate generator: sign-extends the immediate of the selected format.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] insn,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    // Opcode bits carry no immediate data.
    logic unused_opcode;
    assign unused_opcode = ^insn[6:0];

    // Reassemble the scattered immediate fields for each format.
    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I: imm = {{20{insn[31]}}, insn[31:20]};
            IMM_S: imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            IMM_B: imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            IMM_U: imm = {insn[31:12], 12'b0};
            IMM_J: imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: decodes the fetch word, detects load-use hazards and
// registers the result into the DE/EX slot.
//
// Flow control: the slot advances on every posedge unless ex_stall is high,
// in which case it holds and redirect/load-use are ignored. pc_ex_valid kills
// the current word (bubble). A load-use hazard loads a bubble and raises
// stall_req for that one cycle so fetch re-presents the same word.
module decode
    import rv32i_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter bit NOP_ON_ILLEGAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     insn,
    input  logic [XLEN-1:0] pc_de,
    input  logic            ex_stall,
    input  logic            pc_ex_valid,
    output logic            stall_req,
    output logic [4:0]      rf_rs1_addr,
    output logic [4:0]      rf_rs2_addr,
    output logic            de_valid,
    output logic [XLEN-1:0] de_pc,
    output logic [4:0]      de_rs1,
    output logic [4:0]      de_rs2,
    output logic [4:0]      de_rd,
    output logic [31:0]     de_imm,
    output logic [2:0]      de_funct3,
    output logic [3:0]      de_alu_op,
    output logic            de_src_a_pc,
    output logic            de_src_b_imm,
    output logic            de_reg_we,
    output logic            de_mem_re,
    output logic            de_mem_we,
    output logic            de_branch,
    output logic            de_jump,
    output logic            de_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    de_t         dec;
    de_t         de_d;
    de_t         de_q;
    imm_fmt_e    fmt;
    logic [31:0] imm;
    logic        illegal;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        load_use;

    assign opcode = insn[6:0];
    assign rd     = insn[11:7];
    assign funct3 = insn[14:12];
    assign rs1    = insn[19:15];
    assign rs2    = insn[24:20];
    assign funct7 = insn[31:25];

    assign rf_rs1_addr = rs1;
    assign rf_rs2_addr = rs2;

    imm_gen u_imm_gen (
        .insn (insn),
        .fmt  (fmt),
        .imm  (imm)
    );

    // Opcode classification: controls, immediate format, operand usage, legality.
    // ALU B takes the immediate for every class whose ALU result uses it.
    always_comb begin
        dec        = '0;
        dec.pc     = pc_de;
        dec.rs1    = rs1;
        dec.rs2    = rs2;
        dec.rd     = rd;
        dec.funct3 = funct3;
        dec.alu_op = ALU_ADD;
        fmt        = IMM_NONE;
        illegal    = 1'b0;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec.alu_op    = ALU_PASS_B;
                dec.src_b_imm = 1'b1;
                dec.reg_we    = 1'b1;
                fmt           = IMM_U;
                uses_rs1      = 1'b0;
            end
            OPC_AUIPC: begin
                dec.src_a_pc  = 1'b1;
                dec.src_b_imm = 1'b1;
                dec.reg_we    = 1'b1;
                fmt           = IMM_U;
                uses_rs1      = 1'b0;
            end
            OPC_JAL: begin
                dec.jump      = 1'b1;
                dec.src_a_pc  = 1'b1;
                dec.src_b_imm = 1'b1;
                dec.reg_we    = 1'b1;
                fmt           = IMM_J;
                uses_rs1      = 1'b0;
            end
            OPC_JALR: begin
                dec.jump      = 1'b1;
                dec.src_b_imm = 1'b1;
                dec.reg_we    = 1'b1;
                fmt           = IMM_I;
                illegal       = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.branch = 1'b1;
                fmt        = IMM_B;
                uses_rs2   = 1'b1;
                illegal    = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                dec.mem_re    = 1'b1;
                dec.src_b_imm = 1'b1;
                dec.reg_we    = 1'b1;
                fmt           = IMM_I;
                illegal       = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                dec.mem_we    = 1'b1;
                dec.src_b_imm = 1'b1;
                fmt           = IMM_S;
                uses_rs2      = 1'b1;
                illegal       = (funct3 > 3'b010);
            end
            OPC_OP_IMM: begin
                dec.src_b_imm = 1'b1;
                dec.reg_we    = 1'b1;
                dec.alu_op    = base_alu_op(funct3);
                fmt           = IMM_I;
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != FUNCT7_BASE);
                end else if (funct3 == 3'b101) begin
                    if (funct7 == FUNCT7_ALT) begin
                        dec.alu_op = ALU_SRA;
                    end else begin
                        illegal = (funct7 != FUNCT7_BASE);
                    end
                end
            end
            OPC_OP: begin
                dec.reg_we = 1'b1;
                uses_rs2   = 1'b1;
                if (funct7 == FUNCT7_BASE) begin
                    dec.alu_op = base_alu_op(funct3);
                end else if (funct7 == FUNCT7_ALT && funct3 == 3'b000) begin
                    dec.alu_op = ALU_SUB;
                end else if (funct7 == FUNCT7_ALT && funct3 == 3'b101) begin
                    dec.alu_op = ALU_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_FENCE: begin
                illegal = 1'b0;
            end
            OPC_SYSTEM: begin
                illegal = (insn != INSN_ECALL) && (insn != INSN_EBREAK);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        // x0 is never written.
        if (rd == 5'd0) begin
            dec.reg_we = 1'b0;
        end
    end

    // Candidate slot contents: attach the immediate and apply illegal handling.
    always_comb begin
        de_d       = dec;
        de_d.imm   = imm;
        de_d.valid = 1'b1;
        if (illegal) begin
            if (NOP_ON_ILLEGAL) begin
                de_d         = '0;
                de_d.illegal = 1'b1;
            end else begin
                de_d.alu_op    = ALU_ADD;
                de_d.src_a_pc  = 1'b0;
                de_d.src_b_imm = 1'b0;
                de_d.reg_we    = 1'b0;
                de_d.mem_re    = 1'b0;
                de_d.mem_we    = 1'b0;
                de_d.branch    = 1'b0;
                de_d.jump      = 1'b0;
                de_d.illegal   = 1'b1;
            end
        end
    end

    // Hazard: the load in the slot writes a register this word reads.
    always_comb begin
        load_use = de_q.valid && de_q.mem_re && (de_q.rd != 5'd0) &&
                   ((uses_rs1 && (rs1 == de_q.rd)) || (uses_rs2 && (rs2 == de_q.rd)));
        stall_req = rst_n && load_use && !pc_ex_valid && !ex_stall;
    end

    // DE/EX slot: reset > execute stall > redirect > load-use > advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_q <= '0;
        end else if (ex_stall) begin
            de_q <= de_q;
        end else if (pc_ex_valid || load_use) begin
            de_q <= '0;
        end else begin
            de_q <= de_d;
        end
    end

    assign de_valid     = de_q.valid;
    assign de_pc        = de_q.pc;
    assign de_rs1       = de_q.rs1;
    assign de_rs2       = de_q.rs2;
    assign de_rd        = de_q.rd;
    assign de_imm       = de_q.imm;
    assign de_funct3    = de_q.funct3;
    assign de_alu_op    = de_q.alu_op;
    assign de_src_a_pc  = de_q.src_a_pc;
    assign de_src_b_imm = de_q.src_b_imm;
    assign de_reg_we    = de_q.reg_we;
    assign de_mem_re    = de_q.mem_re;
    assign de_mem_we    = de_q.mem_we;
    assign de_branch    = de_q.branch;
    assign de_jump      = de_q.jump;
    assign de_illegal   = de_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for the decode stage.
module tb_decode;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic [3:0]  alu;
        logic        a_pc;
        logic        b_imm;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic        branch;
        logic        jump;
        logic        illegal;
    } exp_t;

    localparam logic [3:0] F3_ALU [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

    localparam int NV = 26;
    localparam logic [31:0] VEC [NV] = '{
        32'h123452B7, 32'h00001317, 32'h010000EF, 32'h00008067, 32'h0020A223,
        32'hFFF00203, 32'h00309093, 32'h4030D093, 32'h40309093, 32'h0FF0000F,
        32'h00000073, 32'h00100073, 32'h34011073, 32'h00009067, 32'h0000A063,
        32'h0000B083, 32'h0020B223, 32'h00500090, 32'h402081B3, 32'h4020D1B3,
        32'h0020B1B3, 32'h00100013, 32'hFFF0A093, 32'h0000A103, 32'h002101B3,
        32'hFE000CE3
    };

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] insn;
    logic [31:0] pc_de;
    logic        ex_stall;
    logic        pc_ex_valid;
    logic        stall_req;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic        de_valid;
    logic [31:0] de_pc;
    logic [4:0]  de_rs1, de_rs2, de_rd;
    logic [31:0] de_imm;
    logic [2:0]  de_funct3;
    logic [3:0]  de_alu_op;
    logic        de_src_a_pc, de_src_b_imm, de_reg_we, de_mem_re, de_mem_we;
    logic        de_branch, de_jump, de_illegal;

    decode dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .insn         (insn),
        .pc_de        (pc_de),
        .ex_stall     (ex_stall),
        .pc_ex_valid  (pc_ex_valid),
        .stall_req    (stall_req),
        .rf_rs1_addr  (rf_rs1_addr),
        .rf_rs2_addr  (rf_rs2_addr),
        .de_valid     (de_valid),
        .de_pc        (de_pc),
        .de_rs1       (de_rs1),
        .de_rs2       (de_rs2),
        .de_rd        (de_rd),
        .de_imm       (de_imm),
        .de_funct3    (de_funct3),
        .de_alu_op    (de_alu_op),
        .de_src_a_pc  (de_src_a_pc),
        .de_src_b_imm (de_src_b_imm),
        .de_reg_we    (de_reg_we),
        .de_mem_re    (de_mem_re),
        .de_mem_we    (de_mem_we),
        .de_branch    (de_branch),
        .de_jump      (de_jump),
        .de_illegal   (de_illegal)
    );

    exp_t act;
    assign act = {de_valid, de_pc, de_rs1, de_rs2, de_rd, de_imm, de_funct3, de_alu_op,
                  de_src_a_pc, de_src_b_imm, de_reg_we, de_mem_re, de_mem_we,
                  de_branch, de_jump, de_illegal};

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural model ----------------
    function automatic exp_t model_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t       d;
        int         x;
        logic       bad;
        logic [2:0] f3;
        logic [6:0] f7;
        d  = '0;
        x  = int'(w);
        f3 = w[14:12];
        f7 = w[31:25];
        bad = 1'b0;
        d.valid  = 1'b1;
        d.pc     = pc;
        d.rs1    = w[19:15];
        d.rs2    = w[24:20];
        d.rd     = w[11:7];
        d.funct3 = f3;
        case (w[6:0])
            7'h37: begin d.alu = 4'd10; d.b_imm = 1; d.reg_we = 1; d.imm = w & 32'hFFFFF000; end
            7'h17: begin d.a_pc = 1; d.b_imm = 1; d.reg_we = 1; d.imm = w & 32'hFFFFF000; end
            7'h6F: begin
                d.jump = 1; d.a_pc = 1; d.b_imm = 1; d.reg_we = 1;
                d.imm = 32'(((x >>> 31) <<< 20) | (int'(w[19:12]) << 12) |
                            (int'(w[20]) << 11) | (int'(w[30:21]) << 1));
            end
            7'h67: begin d.jump = 1; d.b_imm = 1; d.reg_we = 1; d.imm = 32'(x >>> 20); bad = (f3 != 0); end
            7'h63: begin
                d.branch = 1;
                d.imm = 32'(((x >>> 31) <<< 12) | (int'(w[7]) << 11) |
                            (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1));
                bad = (f3 == 2) || (f3 == 3);
            end
            7'h03: begin
                d.mem_re = 1; d.b_imm = 1; d.reg_we = 1; d.imm = 32'(x >>> 20);
                bad = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            end
            7'h23: begin
                d.mem_we = 1; d.b_imm = 1;
                d.imm = 32'(((x >>> 25) <<< 5) | int'(w[11:7]));
                bad = (f3 > 2);
            end
            7'h13: begin
                d.b_imm = 1; d.reg_we = 1; d.imm = 32'(x >>> 20); d.alu = F3_ALU[f3];
                if (f3 == 1) bad = (f7 != 0);
                if (f3 == 5) begin
                    if (f7 == 7'h20) d.alu = 4'd7;
                    else bad = (f7 != 0);
                end
            end
            7'h33: begin
                d.reg_we = 1; d.alu = F3_ALU[f3];
                if (f7 == 7'h20 && f3 == 0) d.alu = 4'd1;
                else if (f7 == 7'h20 && f3 == 5) d.alu = 4'd7;
                else if (f7 != 0) bad = 1;
            end
            7'h0F: bad = 0;
            7'h73: bad = !(w == 32'h00000073 || w == 32'h00100073);
            default: bad = 1;
        endcase
        if (d.rd == 0) d.reg_we = 0;
        if (bad) begin
            d = '0;
            d.illegal = 1;
        end
        return d;
    endfunction

    exp_t m_de = '0;

    function automatic logic model_load_use(input exp_t s, input logic [31:0] w);
        logic r1, r2;
        r1 = !(w[6:0] == 7'h37 || w[6:0] == 7'h17 || w[6:0] == 7'h6F);
        r2 = (w[6:0] == 7'h63 || w[6:0] == 7'h23 || w[6:0] == 7'h33);
        return s.valid && s.mem_re && s.rd != 0 &&
               ((r1 && w[19:15] == s.rd) || (r2 && w[24:20] == s.rd));
    endfunction

    // scoreboard: expected slot per posedge
    logic [$bits(exp_t)-1:0] exp_q[$];

    always @(posedge clk) begin
        exp_t nxt;
        if (!rst_n) nxt = '0;
        else if (ex_stall) nxt = m_de;
        else if (pc_ex_valid || model_load_use(m_de, insn)) nxt = '0;
        else nxt = model_decode(insn, pc_de);
        m_de <= nxt;
        exp_q.push_back(nxt);
    end

    // compare process, away from the active edge
    always @(negedge clk) begin
        logic [$bits(exp_t)-1:0] e;
        logic es;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (act !== e) begin
                n_err++;
                $display("FAIL de_slot t=%0t got=%h exp=%h", $time, act, e);
            end
        end
        es = rst_n && model_load_use(m_de, insn) && !pc_ex_valid && !ex_stall;
        n_vec++;
        if (stall_req !== es) begin
            n_err++;
            $display("FAIL stall_req t=%0t got=%b exp=%b", $time, stall_req, es);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] w, input logic [31:0] pc);
        insn  = w;
        pc_de = pc;
    endtask

    initial begin
        rst_n = 0; ex_stall = 0; pc_ex_valid = 0;
        drive(32'h00500093, 32'h0);
        tick(); tick();
        chk("reset_valid", 32'(de_valid), 32'h0);
        chk("reset_flags", {25'b0, de_reg_we, de_mem_re, de_mem_we, de_branch, de_jump, de_illegal, de_src_b_imm}, 32'h0);
        chk("reset_stall", 32'(stall_req), 32'h0);

        rst_n = 1;
        tick();
        chk("addi_valid", 32'(de_valid), 32'h1);
        chk("addi_rd", 32'(de_rd), 32'h1);
        chk("addi_imm", de_imm, 32'h5);
        chk("addi_alu", 32'(de_alu_op), 32'h0);
        chk("addi_bimm", 32'(de_src_b_imm), 32'h1);
        chk("addi_we", 32'(de_reg_we), 32'h1);

        drive(32'hFE000CE3, 32'h100);
        tick();
        chk("beq_branch", 32'(de_branch), 32'h1);
        chk("beq_imm", de_imm, 32'hFFFFFFF8);
        chk("beq_pc", de_pc, 32'h100);
        chk("beq_we", 32'(de_reg_we), 32'h0);

        // load-use: lw x2 then add x3,x2,x2
        drive(32'h0000A103, 32'h104);
        tick();
        drive(32'h002101B3, 32'h108);
        #1;
        chk("lu_stall_on", 32'(stall_req), 32'h1);
        tick();
        chk("lu_bubble", 32'(de_valid), 32'h0);
        chk("lu_stall_off", 32'(stall_req), 32'h0);
        tick();
        chk("lu_add_valid", 32'(de_valid), 32'h1);
        chk("lu_add_rs", {de_rs1, de_rs2}, {5'd2, 5'd2});

        // rd = x0 load never stalls
        drive(32'h0000A003, 32'h10C);
        tick();
        drive(32'h000001B3, 32'h110);
        #1;
        chk("lu_x0_stall", 32'(stall_req), 32'h0);
        tick();
        chk("lu_x0_add", 32'(de_valid), 32'h1);

        // redirect kills current word
        drive(32'h00500093, 32'h114);
        pc_ex_valid = 1;
        tick();
        pc_ex_valid = 0;
        chk("redirect_bubble", 32'(de_valid), 32'h0);

        // ex_stall freezes the slot, also against a redirect
        drive(32'h00700293, 32'h200);
        tick();
        ex_stall = 1;
        drive(32'h002101B3, 32'h204);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_rd", 32'(de_rd), 32'h5);
            chk("stall_hold_pc", de_pc, 32'h200);
        end
        pc_ex_valid = 1;
        tick();
        chk("stall_redirect_held", {de_valid, de_imm[30:0]}, {1'b1, 31'h7});
        ex_stall = 0; pc_ex_valid = 0;
        tick();
        chk("stall_release", 32'(de_rd), 32'h3);

        // illegal words
        drive(32'hFFFFFFFF, 32'h300);
        tick();
        chk("ill_ffff", {de_illegal, de_valid, de_reg_we, de_mem_we}, 32'h8);
        drive(32'h403140B3, 32'h304);
        tick();
        chk("ill_xor_sub", {de_illegal, de_valid, de_reg_we, de_mem_we}, 32'h8);

        // reset during a load-use stall drops everything
        drive(32'h0000A103, 32'h400);
        tick();
        drive(32'h002101B3, 32'h404);
        rst_n = 0;
        #1;
        chk("rst_mid_stall", 32'(stall_req), 32'h0);
        tick();
        chk("rst_mid_valid", 32'(de_valid), 32'h0);
        rst_n = 1;

        // directed table, clean pass
        for (int i = 0; i < NV; i++) begin
            drive(VEC[i], 32'h1000 + 32'(i * 4));
            tick();
        end
        // directed table with sporadic stalls and redirects
        for (int i = 0; i < NV; i++) begin
            drive(VEC[i], 32'h2000 + 32'(i * 4));
            ex_stall    = ($urandom_range(0, 3) == 0);
            pc_ex_valid = ($urandom_range(0, 4) == 0);
            tick();
        end
        ex_stall = 0; pc_ex_valid = 0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- RV32I decode stage, directly downstream of fetch.
- Consumes the instruction word and its PC presented combinationally by fetch. Decodes them and registers the result into the DE/EX pipeline register that execute consumes.
- Owns load-use hazard detection: raises a stall request back to fetch and inserts a bubble.
- Kills the wrong-path instruction when execute redirects the PC.

Parameters:
- XLEN, 32, datapath/PC width; only 32 supported.
- NOP_ON_ILLEGAL, 1, 1: an illegal instruction is emitted as a bubble with de_illegal=1. 0: it is passed with controls cleared.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- insn  in  32  instruction word from fetch, valid in the same cycle as pc_de
- pc_de  in  32  PC of insn
- ex_stall  in  1  execute stall; same signal fetch receives
- pc_ex_valid  in  1  execute redirect (taken branch/jump); same signal fetch receives
- stall_req  out  1  load-use stall to fetch; ORed with ex_stall at top level
- rf_rs1_addr  out  5  combinational insn[19:15] for synchronous regfile read
- rf_rs2_addr  out  5  combinational insn[24:20]
- de_valid  out  1  DE/EX slot holds a real instruction
- de_pc  out  32  PC of decoded instruction
- de_rs1, de_rs2, de_rd  out  5 each  register indices
- de_imm  out  32  sign-extended immediate
- de_funct3  out  3  passed to branch/LSU
- de_alu_op  out  4  ALU operation code (package enum)
- de_src_a_pc  out  1  ALU A = PC (AUIPC, JAL)
- de_src_b_imm  out  1  ALU B = imm
- de_reg_we, de_mem_re, de_mem_we, de_branch, de_jump, de_illegal  out  1 each  control flags

Behaviour:
- All de_* registered on posedge clk. Latency 1: insn present in cycle N appears on de_* in cycle N+1.
- Bubble: de_valid=0, all control flags=0, all other de_* fields=0.
- Reset: rst_n=0 at a posedge loads a bubble. stall_req=0 while rst_n=0. A reset mid-stall drops the held instruction.
- Per-posedge priority (highest first):
  1. reset: load bubble.
  2. ex_stall=1: hold all de_* unchanged; ignore pc_ex_valid and load-use, matching fetch, which also ignores a redirect while stalled.
  3. pc_ex_valid=1: load bubble; the current insn is wrong-path.
  4. load-use: load bubble.
  5. Otherwise: load the decoded insn with de_valid=1.
- Load-use condition, combinational: de_valid & de_mem_re & de_rd!=0 & ((uses_rs1 & rs1==de_rd) | (uses_rs2 & rs2==de_rd)).
  - stall_req = load-use & ~pc_ex_valid & ~ex_stall.
  - The stall lasts exactly 1 cycle: the bubble clears the condition.
- uses_rs1: all formats except LUI, AUIPC, JAL. uses_rs2: BRANCH, STORE, OP only.
- Opcode classes:
  - LUI: alu PASS_B, imm_u, reg_we.
  - AUIPC: ADD, src_a_pc, imm_u, reg_we.
  - JAL: jump, src_a_pc, imm_j, reg_we.
  - JALR: jump, imm_i, reg_we; funct3 must be 000.
  - BRANCH: branch, imm_b; funct3 010/011 illegal.
  - LOAD: mem_re, imm_i, ADD, reg_we; funct3 in {000,001,010,100,101}.
  - STORE: mem_we, imm_s, ADD; funct3 in {000,001,010}.
  - OP-IMM: imm_i, src_b_imm. For SLLI/SRLI/SRAI, insn[31:25] must be 0000000 or 0100000 (SRAI only), else illegal.
  - OP: funct7 0000000, or 0100000 for SUB/SRA only.
  - FENCE: valid no-op.
  - SYSTEM: ECALL/EBREAK are valid no-ops with de_illegal=0. Anything else is illegal.
  - Any other opcode, or insn[1:0]!=11: illegal.
- de_reg_we forced 0 when rd==0.
- Immediates are sign-extended from insn[31]. The B and J immediates have bit0=0.

Decomposition:
- Package rv32i_pkg holds:
  - opcode localparams (OPC_LUI=7'b0110111, etc.).
  - ALU op codes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10.
  - the funct7 constants.
- One sub-module, imm_gen: combinational, insn[31:0] + format select -> imm[31:0]. Reused by execute tests.

Test Plan:
- Reset: rst_n=0 for 2 cycles with insn=0x00500093 -> de_valid=0, all flags 0, stall_req=0. Release -> next cycle de_valid=1.
- addi x1,x0,5 (0x00500093) -> next cycle de_rd=1, de_imm=5, alu ADD, de_src_b_imm=1, de_reg_we=1.
- beq x0,x0,-8 (0xFE000CE3) at pc 0x100 -> de_branch=1, de_imm=0xFFFFFFF8, de_pc=0x100, de_reg_we=0.
- Load-use: lw x2,0(x1) (0x0000A103) then add x3,x2,x2 (0x002101B3) -> stall_req=1 for exactly 1 cycle, one bubble, then add with de_rs1=de_rs2=2. Repeat with rd=x0 -> no stall.
- Redirect/stall: pc_ex_valid=1 -> bubble next cycle. ex_stall=1 for 3 cycles -> de_* frozen. ex_stall=1 with pc_ex_valid=1 -> redirect ignored, de_* held.
- Illegal: insn=0xFFFFFFFF, and SUB-encoded funct7 on XOR -> de_illegal=1, de_valid=0 (NOP_ON_ILLEGAL=1), reg_we=mem_we=0.
